// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU operand-issue stage.
//   alu_op_e   : ALU opcode encoding (000 add ... 111 pass b)
//   ex_reg_t   : contents of the EX (operand) register {op, rd, a, b}
//   FLAG_*     : bit positions inside the {overflow, negative, zero} flag vector
// ISSUE_BW / ISSUE_NREG size ex_reg_t; the issue stage parameters default to
// them, so change both together when retargeting the datapath width.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ISSUE_BW   = 16;
    localparam int ISSUE_NREG = 8;
    localparam int ISSUE_AW   = $clog2(ISSUE_NREG);

    localparam int FLAG_OVF  = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [2:0] {
        ADD   = 3'd0,
        SUB   = 3'd1,
        AND   = 3'd2,
        OR    = 3'd3,
        XOR   = 3'd4,
        INC   = 3'd5,
        PASSA = 3'd6,
        PASSB = 3'd7
    } alu_op_e;

    typedef struct packed {
        alu_op_e               op;
        logic [ISSUE_AW-1:0]   rd;
        logic [ISSUE_BW-1:0]   a;
        logic [ISSUE_BW-1:0]   b;
    } ex_reg_t;

endpackage

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
// NREG x BW register file, cleared by reset, one synchronous write port and
// three combinational read ports (two operand reads plus a debug read).
// A write at an edge is not visible on the read ports until after that edge.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   we, waddr, wdata      write port
//   ra_addr -> ra_data    operand A read
//   rb_addr -> rb_data    operand B read
//   dbg_addr -> dbg_data  debug read
// ---------------------------------------------------------------------------
module alu_regfile #(
    parameter  int BW   = 16,
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [BW-1:0] wdata,
    input  logic [AW-1:0] ra_addr,
    output logic [BW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [BW-1:0] rb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [BW-1:0] dbg_data
);

    logic [BW-1:0]   rf_q [NREG];
    logic [NREG-1:0] wr_sel;

    // One-hot write decode; an out-of-range waddr (non power-of-two NREG)
    // simply selects nothing.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_wr_sel
            assign wr_sel[gi] = we && (waddr == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_sel[i]) begin
                    rf_q[i] <= wdata;
                end
            end
        end
    end

    assign ra_data  = rf_q[ra_addr];
    assign rb_data  = rf_q[rb_addr];
    assign dbg_data = rf_q[dbg_addr];

endmodule

// File: rtl/alu_operand_issue.sv
// ---------------------------------------------------------------------------
// alu_operand_issue
// Issue stage in front of a combinational ALU. Instructions {opcode, rd, ra,
// rb} are accepted over valid/ready, their operands are read from the
// register file into the EX register that drives the ALU, and one edge later
// the ALU result is written back to rd and the ALU flags are latched.
// Read-after-write on the in-flight EX instruction either stalls one cycle
// (default) or forwards the writeback data (macro ALU_ISSUE_BYPASS_EN).
// Ports:
//   clk, rst                                   clock, async active-high reset
//   instr_valid/instr_ready                    instruction handshake
//   instr_opcode, instr_rd, instr_ra, instr_rb instruction fields
//   alu_a, alu_b, alu_opcode                   to the ALU (from EX register)
//   alu_out, alu_flags                         from the ALU
//   wb_valid, wb_rd, wb_data                   writeback happening at next edge
//   flags_q                                    flags of last completed instr
//   dbg_addr -> dbg_data                       combinational register peek
// Configuration macro: ALU_ISSUE_BYPASS_EN
// ---------------------------------------------------------------------------
module alu_operand_issue
    import alu_pkg::*;
#(
    parameter  int BW   = ISSUE_BW,
    parameter  int NREG = ISSUE_NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_opcode,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_ra,
    input  logic [AW-1:0] instr_rb,
    output logic [BW-1:0] alu_a,
    output logic [BW-1:0] alu_b,
    output logic [2:0]    alu_opcode,
    input  logic [BW:0]   alu_out,
    input  logic [2:0]    alu_flags,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [BW-1:0] wb_data,
    output logic [2:0]    flags_q,
    input  logic [AW-1:0] dbg_addr,
    output logic [BW-1:0] dbg_data
);

    ex_reg_t       ex_q;
    ex_reg_t       ex_d;
    logic          ex_valid_q;
    logic [BW-1:0] rf_a;
    logic [BW-1:0] rf_b;
    logic [BW-1:0] op_a;
    logic [BW-1:0] op_b;
    logic          hz_a;
    logic          hz_b;
    logic          hz;
    logic          accept;
    // The ALU's extra result bit is not architecturally stored.
    logic          unused_alu_msb;

    assign unused_alu_msb = alu_out[BW];

    alu_regfile #(
        .BW   (BW),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (ex_valid_q),
        .waddr    (ex_q.rd),
        .wdata    (wb_data),
        .ra_addr  (instr_ra),
        .ra_data  (rf_a),
        .rb_addr  (instr_rb),
        .rb_data  (rf_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // The register file only reflects the EX result after the coming edge,
    // so any source matching the in-flight destination is a hazard.
    assign hz_a = ex_valid_q && (instr_ra == ex_q.rd);
    assign hz_b = ex_valid_q && (instr_rb == ex_q.rd);
    assign hz   = hz_a || hz_b;

`ifdef ALU_ISSUE_BYPASS_EN
    assign instr_ready = 1'b1;
    assign op_a        = hz_a ? wb_data : rf_a;
    assign op_b        = hz_b ? wb_data : rf_b;
`else
    // Stall one cycle; by then the writeback has landed in the register file.
    assign instr_ready = !hz;
    assign op_a        = rf_a;
    assign op_b        = rf_b;
`endif

    assign accept = instr_valid && instr_ready;

    // EX fields keep their last values while no instruction is accepted.
    always_comb begin
        ex_d = ex_q;
        if (accept) begin
            ex_d.op = alu_op_e'(instr_opcode);
            ex_d.rd = instr_rd;
            ex_d.a  = op_a;
            ex_d.b  = op_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
            flags_q    <= 3'b000;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= accept;
            if (ex_valid_q) begin
                flags_q <= alu_flags;
            end
        end
    end

    assign alu_a      = ex_q.a;
    assign alu_b      = ex_q.b;
    assign alu_opcode = ex_q.op;

    assign wb_valid = ex_valid_q;
    assign wb_rd    = ex_q.rd;
    assign wb_data  = alu_out[BW-1:0];

endmodule

// File: tb/tb_alu_operand_issue.sv
module tb_alu_operand_issue;
    import alu_pkg::*;

    localparam int BW   = 16;
    localparam int NREG = 8;
    localparam int AW   = 3;
`ifdef ALU_ISSUE_BYPASS_EN
    localparam int EXP_BUBBLE = 0;
`else
    localparam int EXP_BUBBLE = 1;
`endif

    logic          clk;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    instr_opcode;
    logic [AW-1:0] instr_rd;
    logic [AW-1:0] instr_ra;
    logic [AW-1:0] instr_rb;
    logic [BW-1:0] alu_a;
    logic [BW-1:0] alu_b;
    logic [2:0]    alu_opcode;
    logic [BW:0]   alu_out;
    logic [2:0]    alu_flags;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [BW-1:0] wb_data;
    logic [2:0]    flags_q;
    logic [AW-1:0] dbg_addr;
    logic [BW-1:0] dbg_data;

    int n_checks = 0;
    int n_pass   = 0;

    alu_operand_issue #(.BW(BW), .NREG(NREG)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_rd     (instr_rd),
        .instr_ra     (instr_ra),
        .instr_rb     (instr_rb),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_out      (alu_out),
        .alu_flags    (alu_flags),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flags_q      (flags_q),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ALU behaviour (signed, BW+1 result) ----------------
    function automatic logic [BW:0] eval_full(input logic [2:0] op,
                                              input logic [BW-1:0] a,
                                              input logic [BW-1:0] b);
        logic [BW:0] sa;
        logic [BW:0] sb;
        logic [BW:0] t;
        sa = {a[BW-1], a};
        sb = {b[BW-1], b};
        case (op)
            3'd0:    t = sa + sb;
            3'd1:    t = sa - sb;
            3'd2:    t = sa & sb;
            3'd3:    t = sa | sb;
            3'd4:    t = sa ^ sb;
            3'd5:    t = sa + (BW+1)'(1);
            3'd6:    t = sa;
            default: t = sb;
        endcase
        return t;
    endfunction

    function automatic logic [2:0] eval_flags(input logic [2:0] op,
                                              input logic [BW-1:0] a,
                                              input logic [BW-1:0] b);
        logic [BW:0] t;
        logic        arith;
        t     = eval_full(op, a, b);
        arith = (op == 3'd0) || (op == 3'd1) || (op == 3'd5);
        return {arith && (t[BW] ^ t[BW-1]), t[BW], (t == '0)};
    endfunction

    function automatic logic [BW-1:0] eval_data(input logic [2:0] op,
                                                input logic [BW-1:0] a,
                                                input logic [BW-1:0] b);
        logic [BW:0] t;
        t = eval_full(op, a, b);
        return t[BW-1:0];
    endfunction

    always_comb begin
        alu_out   = eval_full(alu_opcode, alu_a, alu_b);
        alu_flags = eval_flags(alu_opcode, alu_a, alu_b);
    end

    // ---------------- Reference model ----------------
    // arch_rf: register values as seen by program order (updated at accept).
    // vis_rf : what the register file shows (one edge after accept).
    logic [BW-1:0] arch_rf [NREG];
    logic [BW-1:0] vis_rf  [NREG];
    logic          pend_v;
    logic [AW-1:0] pend_rd;
    logic [BW-1:0] pend_res;
    logic [2:0]    pend_flags;
    logic [2:0]    m_flags;

    function automatic logic model_ready();
`ifdef ALU_ISSUE_BYPASS_EN
        return 1'b1;
`else
        return !(pend_v && (instr_ra == pend_rd || instr_rb == pend_rd));
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                arch_rf[i] <= '0;
                vis_rf[i]  <= '0;
            end
            pend_v     <= 1'b0;
            pend_rd    <= '0;
            pend_res   <= '0;
            pend_flags <= '0;
            m_flags    <= '0;
        end else begin
            if (pend_v) begin
                vis_rf[pend_rd] <= pend_res;
                m_flags         <= pend_flags;
            end
            if (instr_valid && model_ready()) begin
                pend_res   <= eval_data(instr_opcode, arch_rf[instr_ra], arch_rf[instr_rb]);
                pend_flags <= eval_flags(instr_opcode, arch_rf[instr_ra], arch_rf[instr_rb]);
                arch_rf[instr_rd] <= eval_data(instr_opcode, arch_rf[instr_ra], arch_rf[instr_rb]);
                pend_rd    <= instr_rd;
                pend_v     <= 1'b1;
            end else begin
                pend_v <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready", 32'(instr_ready), 32'(model_ready()));
            chk("wb_valid", 32'(wb_valid), 32'(pend_v));
            if (pend_v) begin
                chk("wb_rd", 32'(wb_rd), 32'(pend_rd));
                chk("wb_data", 32'(wb_data), 32'(pend_res));
            end
            chk("flags_q", 32'(flags_q), 32'(m_flags));
            chk("dbg_data", 32'(dbg_data), 32'(vis_rf[dbg_addr]));
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic issue(input alu_op_e op, input int rd, input int ra, input int rb,
                         output int stalls);
        int guard;
        stalls       = 0;
        guard        = 0;
        instr_valid  = 1'b1;
        instr_opcode = op;
        instr_rd     = AW'(rd);
        instr_ra     = AW'(ra);
        instr_rb     = AW'(rb);
        @(negedge clk);
        while (!instr_ready && guard < 20) begin
            stalls++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 20) begin
            n_checks++;
            $display("FAIL issue_timeout: instr_ready low for %0d cycles, required accept", guard);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        $display("issue op=%0d rd=r%0d ra=r%0d rb=r%0d stalls=%0d", op, rd, ra, rb, stalls);
    endtask

    task automatic iss(input alu_op_e op, input int rd, input int ra, input int rb);
        int s;
        issue(op, rd, ra, rb, s);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string name, input int idx, input logic [BW-1:0] exp);
        dbg_addr = AW'(idx);
        #1;
        chk(name, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        rst          = 1'b1;
        instr_valid  = 1'b0;
        instr_opcode = '0;
        instr_rd     = '0;
        instr_ra     = '0;
        instr_rb     = '0;
        dbg_addr     = '0;

        // 1. Reset state
        #12;
        for (int i = 0; i < NREG; i++) begin
            check_reg("rst_rf", i, 16'h0000);
        end
        chk("rst_wb_valid", 32'(wb_valid), 32'(0));
        chk("rst_flags", 32'(flags_q), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        chk("ready_after_rst", 32'(instr_ready), 32'(1));

        // Seeding r1=5, r2=7
        repeat (5) iss(INC, 1, 1, 0);
        repeat (7) iss(INC, 2, 2, 0);
        idle(2);
        check_reg("seed_r1", 1, 16'd5);
        check_reg("seed_r2", 2, 16'd7);

        // 2. ADD r3 = r1 + r2, one edge of latency
        iss(ADD, 3, 1, 2);
        check_reg("r3_not_yet", 3, 16'd0);
        idle(1);
        check_reg("add_r3", 3, 16'd12);
        chk("add_flags", 32'(flags_q), 32'(3'b000));

        // 3. Independent back-to-back
        iss(SUB, 4, 1, 1);
        issue(OR, 5, 1, 2, st);
        chk("sub_flags", 32'(flags_q), 32'(3'b001));
        chk("or_no_stall", 32'(st), 32'(0));
        idle(1);
        check_reg("sub_r4", 4, 16'd0);
        check_reg("or_r5", 5, 16'd7);
        chk("or_flags", 32'(flags_q), 32'(3'b000));

        // 4. Dependent pair
        idle(1);
        iss(ADD, 6, 1, 2);
        issue(ADD, 7, 6, 1, st);
        chk("dep_bubbles", 32'(st), 32'(EXP_BUBBLE));
        idle(2);
        check_reg("dep_r6", 6, 16'd12);
        check_reg("dep_r7", 7, 16'd17);

        // 5. Overflow: build r1 = 0x7FFF through doubling, then r2 = r1 + r1
        iss(INC, 4, 0, 0);
        iss(ADD, 1, 4, 4);
        repeat (14) iss(ADD, 1, 1, 1);
        iss(SUB, 1, 1, 4);
        idle(2);
        check_reg("seed_7fff", 1, 16'h7FFF);
        iss(ADD, 2, 1, 1);
        idle(1);
        check_reg("ovf_r2", 2, 16'hFFFE);
        chk("ovf_flag", 32'(flags_q[FLAG_OVF]), 32'(1));
        chk("ovf_neg", 32'(flags_q[FLAG_NEG]), 32'(0));
        chk("ovf_flags", 32'(flags_q), 32'(3'b100));

        // 6. Reset while ADD r3 is in EX
        idle(1);
        check_reg("pre_rst_r3", 3, 16'd12);
        instr_valid  = 1'b1;
        instr_opcode = ADD;
        instr_rd     = 3'd3;
        instr_ra     = 3'd1;
        instr_rb     = 3'd2;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("midop_wb_valid", 32'(wb_valid), 32'(1));
        chk("midop_wb_rd", 32'(wb_rd), 32'(3));
        chk("midop_wb_data", 32'(wb_data), 32'(16'h7FFD));
        #1;
        rst = 1'b1;
        #1;
        chk("async_wb_valid", 32'(wb_valid), 32'(0));
        check_reg("rst_r3", 3, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        check_reg("post_rst_r3", 3, 16'd0);
        check_reg("post_rst_r1", 1, 16'd0);
        chk("post_rst_flags", 32'(flags_q), 32'(0));
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
